seq_checker: RTL and testbench
==============================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter LOCK_THRESH, default 6, consecutive in-sequence samples needed to enter LOCKED (range 2..15).
REQ-002 Parameter UNLOCK_THRESH, default 2, consecutive mismatches in LOCKED that force return to HUNT (range 1..15).
REQ-003 clk  input  1  rising-edge clock, shared with the upstream sequence counter.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 valid_in  input  1  sample strobe; data_in is evaluated only on edges where valid_in=1.
REQ-006 data_in  input  4  value from the upstream counter; legal sequence 0,2,5,8,11,14,0,...
REQ-007 locked  output  1  high while in LOCKED state.
REQ-008 err_pulse  output  1  one-cycle pulse per mismatch detected in LOCKED.
REQ-009 wrap_pulse  output  1  one-cycle pulse per accepted 14->0 transition in LOCKED.
REQ-010 err_count  output  8  mismatches counted in LOCKED, saturating at 255.
REQ-011 wrap_count  output  8  accepted wraps in LOCKED, wrapping modulo 256.
REQ-012 expected  output  4  value the checker expects on the next valid sample.

Function
REQ-013 Successor function: 0->2, 2->5, 5->8, 8->11, 11->14, 14->0; any other value is illegal and has no successor.
REQ-014 States: HUNT, TRACK, LOCKED; all outputs are registered and reflect a sample on the clock edge at which it is taken (one-cycle latency relative to data_in).
REQ-015 Edges with valid_in=0 change no state, counter, or output; pulses are deasserted.
REQ-016 HUNT: sample 0 -> TRACK, match count=1, expected=2; any other sample -> stay in HUNT, expected=0.
REQ-017 TRACK: sample==expected -> match count+1, expected=successor; on reaching LOCK_THRESH -> LOCKED.
REQ-018 TRACK: mismatch with sample==0 -> remain in TRACK, match count=1, expected=2 (re-arm; absorbs the repeated 0 the counter emits after reset).
REQ-019 TRACK: any other mismatch -> HUNT, expected=0, no error counted.
REQ-020 LOCKED: sample==expected -> miss count=0, expected=successor; if the sample is 0 and the previous expected was 0, pulse wrap_pulse and increment wrap_count.
REQ-021 LOCKED: mismatch -> pulse err_pulse, increment err_count (hold at 255), miss count+1, expected=successor(expected) (flywheel).
REQ-022 LOCKED: miss count reaching UNLOCK_THRESH -> HUNT, locked=0 on the same edge, expected=0; err_count and wrap_count retained.
REQ-023 err_count and wrap_count change only in LOCKED and are cleared only by reset.
REQ-024 Match and miss counters are 4 bits wide and clear on every state change.

Reset
REQ-025 reset asserted -> state=HUNT, match/miss counts=0, expected=0, locked=0, err_pulse=0, wrap_pulse=0, err_count=0, wrap_count=0, immediately and without waiting for clk.
REQ-026 Reset asserted mid-sequence in any state discards all progress; after release, the first valid sample is evaluated per REQ-016.

Structure
REQ-027 Shared package seq_chk_pkg holds the state enumeration, the six sequence constants (0,2,5,8,11,14), and the counter widths.
REQ-028 Sub-module seq_next_lut (combinational: 4-bit value in -> 4-bit successor plus legal flag) is used for both sample and expected successor lookup.
REQ-029 A single clocked process holds state, counters, and registered outputs; no latches and no combinational outputs.

Verification
REQ-030 Reset, then valid_in=1 with the stream 0,0,2,5,8,11,14,0,2 -> locked rises on the edge that samples the second 14-following... specifically on the edge sampling 14 (sixth match after re-arm); wrap_pulse on the following 0; wrap_count=1.
REQ-031 Locked stream, inject 7 in place of 8 once -> single err_pulse, err_count=1, locked stays 1, the next sample 11 is accepted with no further error.
REQ-032 Locked stream, two consecutive bad samples 3,3 -> two err_pulses, err_count=2, locked=0 after the second, expected=0.
REQ-033 Force 300 mismatches across repeated lock/unlock cycles -> err_count saturates at 255; 256 wraps -> wrap_count returns to 0.
REQ-034 valid_in toggling 1,0,1,0 across a legal stream -> identical lock timing in valid samples; no pulses on idle edges.
REQ-035 Assert reset asynchronously between clock edges while LOCKED -> all outputs 0 immediately; relock requires a full LOCK_THRESH run.

Source files
------------

// File: rtl/seq_chk_pkg.sv
// seq_chk_pkg: shared states, sequence constants and widths for the sequence checker
package seq_chk_pkg;
  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;
  localparam int STAT_W = 8;
  localparam logic [DATA_W-1:0] SEQ_0 = 4'd0;
  localparam logic [DATA_W-1:0] SEQ_1 = 4'd2;
  localparam logic [DATA_W-1:0] SEQ_2 = 4'd5;
  localparam logic [DATA_W-1:0] SEQ_3 = 4'd8;
  localparam logic [DATA_W-1:0] SEQ_4 = 4'd11;
  localparam logic [DATA_W-1:0] SEQ_5 = 4'd14;
endpackage

// File: rtl/seq_checker_if.sv
// seq_checker_if: sample stream in, lock status and statistics out
interface seq_checker_if;
  import seq_chk_pkg::*;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              locked;
  logic              err_pulse;
  logic              wrap_pulse;
  logic [STAT_W-1:0] err_count;
  logic [STAT_W-1:0] wrap_count;
  logic [DATA_W-1:0] expected;
  modport master (
    output valid_in, data_in,
    input  locked, err_pulse, wrap_pulse, err_count, wrap_count, expected
  );
  modport slave (
    input  valid_in, data_in,
    output locked, err_pulse, wrap_pulse, err_count, wrap_count, expected
  );
endinterface

// File: rtl/seq_next_lut.sv
// seq_next_lut: successor of a sequence value and whether the value is legal at all
module seq_next_lut
  import seq_chk_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] succ,
  output logic              legal
);
  // illegal values map to SEQ_0 but are flagged so callers never treat them as in-sequence
  always_comb begin
    succ  = value == SEQ_0 ? SEQ_1 :
            value == SEQ_1 ? SEQ_2 :
            value == SEQ_2 ? SEQ_3 :
            value == SEQ_3 ? SEQ_4 :
            value == SEQ_4 ? SEQ_5 : SEQ_0;
    legal = value inside {SEQ_0, SEQ_1, SEQ_2, SEQ_3, SEQ_4, SEQ_5};
  end
endmodule

// File: rtl/seq_checker.sv
// seq_checker: hunts for, locks onto and monitors the 0,2,5,8,11,14 counter stream
module seq_checker
  import seq_chk_pkg::*;
#(
  parameter int LOCK_THRESH   = 6,
  parameter int UNLOCK_THRESH = 2
) (
  input logic         clk,
  input logic         reset,
  seq_checker_if.slave bus
);
  state_t            state;
  logic [CNT_W-1:0]  match_cnt;
  logic [CNT_W-1:0]  miss_cnt;
  logic [DATA_W-1:0] expected_q;
  logic              locked_q;
  logic              err_pulse_q;
  logic              wrap_pulse_q;
  logic [STAT_W-1:0] err_cnt;
  logic [STAT_W-1:0] wrap_cnt;
  logic [DATA_W-1:0] s_succ;
  logic [DATA_W-1:0] e_succ;
  logic              s_legal;
  logic              e_legal;
  logic              match;
  logic [CNT_W-1:0]  match_inc;
  logic [CNT_W-1:0]  miss_inc;

  seq_next_lut u_sample_lut (.value(bus.data_in), .succ(s_succ), .legal(s_legal));
  seq_next_lut u_expect_lut (.value(expected_q),  .succ(e_succ), .legal(e_legal));

  // a sample is in-sequence only if it is a legal value equal to the prediction
  always_comb begin
    match     = s_legal && e_legal && bus.data_in == expected_q;
    match_inc = match_cnt + 1'b1;
    miss_inc  = miss_cnt + 1'b1;
  end

  // tracking FSM with all status and statistics registered alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      expected_q   <= SEQ_0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_cnt      <= '0;
      wrap_cnt     <= '0;
    end else begin
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      if (bus.valid_in) begin
        case (state)
          HUNT: begin
            if (bus.data_in == SEQ_0) begin
              state      <= TRACK;
              match_cnt  <= CNT_W'(1);
              miss_cnt   <= '0;
              expected_q <= SEQ_1;
            end else begin
              expected_q <= SEQ_0;
            end
          end
          TRACK: begin
            if (match) begin
              expected_q <= s_succ;
              if (match_inc == CNT_W'(LOCK_THRESH)) begin
                state     <= LOCKED;
                locked_q  <= 1'b1;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_inc;
              end
            end else if (bus.data_in == SEQ_0) begin
              // a repeated 0 right after counter reset simply restarts the run
              match_cnt  <= CNT_W'(1);
              expected_q <= SEQ_1;
            end else begin
              state      <= HUNT;
              match_cnt  <= '0;
              miss_cnt   <= '0;
              expected_q <= SEQ_0;
            end
          end
          LOCKED: begin
            if (match) begin
              miss_cnt   <= '0;
              expected_q <= s_succ;
              if (bus.data_in == SEQ_0) begin
                wrap_pulse_q <= 1'b1;
                wrap_cnt     <= wrap_cnt + 1'b1;
              end
            end else begin
              err_pulse_q <= 1'b1;
              err_cnt     <= &err_cnt ? err_cnt : err_cnt + 1'b1;
              if (miss_inc == CNT_W'(UNLOCK_THRESH)) begin
                state      <= HUNT;
                locked_q   <= 1'b0;
                match_cnt  <= '0;
                miss_cnt   <= '0;
                expected_q <= SEQ_0;
              end else begin
                // flywheel: keep predicting as if the bad sample had been correct
                miss_cnt   <= miss_inc;
                expected_q <= e_succ;
              end
            end
          end
          default: begin
            state      <= HUNT;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            expected_q <= SEQ_0;
            locked_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.err_count  = err_cnt;
  assign bus.wrap_count = wrap_cnt;
  assign bus.expected   = expected_q;
endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: directed stimulus with hand-computed expectations for seq_checker
module tb_seq_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_checker_if bus();

  seq_checker #(.LOCK_THRESH(6), .UNLOCK_THRESH(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int lk, input int ep, input int wp,
                         input int ec, input int wc, input int ex);
    chk({tag, ".locked"},     32'(bus.locked),     lk);
    chk({tag, ".err_pulse"},  32'(bus.err_pulse),  ep);
    chk({tag, ".wrap_pulse"}, 32'(bus.wrap_pulse), wp);
    chk({tag, ".err_count"},  32'(bus.err_count),  ec);
    chk({tag, ".wrap_count"}, 32'(bus.wrap_count), wc);
    chk({tag, ".expected"},   32'(bus.expected),   ex);
  endtask

  task automatic step(input logic v, input logic [3:0] d);
    @(negedge clk);
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.valid_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int ec_model;
    bus.valid_in = 1'b0;
    bus.data_in  = 4'd0;
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    step(1, 0);  chk_all("first0", 0, 0, 0, 0, 0, 2);
    step(1, 0);  chk_all("rearm0", 0, 0, 0, 0, 0, 2);
    step(1, 2);  chk("t2.exp", bus.expected, 5);
    step(1, 5);  chk("t5.exp", bus.expected, 8);
    step(1, 8);  chk("t8.exp", bus.expected, 11);
    step(1, 11); chk_all("t11", 0, 0, 0, 0, 0, 14);
    step(1, 14); chk_all("lock14", 1, 0, 0, 0, 0, 0);
    step(1, 0);  chk_all("wrap0", 1, 0, 1, 0, 1, 2);
    step(1, 2);  chk_all("after_wrap", 1, 0, 0, 0, 1, 5);

    step(1, 5);  chk("l5.exp", bus.expected, 8);
    step(1, 7);  chk_all("bad7", 1, 1, 0, 1, 1, 11);
    step(1, 11); chk_all("ok11", 1, 0, 0, 1, 1, 14);
    step(1, 14); chk("l14.exp", bus.expected, 0);
    step(1, 3);  chk_all("bad3a", 1, 1, 0, 2, 1, 2);
    step(1, 3);  chk_all("bad3b", 0, 1, 0, 3, 1, 0);
    step(1, 3);  chk_all("hunt3", 0, 0, 0, 3, 1, 0);

    step(1, 0);  chk("g0.exp", bus.expected, 2);
    step(0, 9);  chk("idle_g0.exp", bus.expected, 2);
    step(1, 2);  chk("g2.exp", bus.expected, 5);
    step(0, 0);  chk("idle_g2.exp", bus.expected, 5);
    step(1, 5);
    step(0, 3);
    step(1, 8);
    step(0, 1);
    step(1, 11); chk_all("g11", 0, 0, 0, 3, 1, 14);
    step(0, 4);  chk_all("idle_g11", 0, 0, 0, 3, 1, 14);
    step(1, 14); chk_all("g14", 1, 0, 0, 3, 1, 0);
    step(0, 6);  chk_all("idle_g14", 1, 0, 0, 3, 1, 0);
    step(1, 0);  chk_all("gwrap", 1, 0, 1, 3, 2, 2);
    step(0, 0);  chk_all("idle_gwrap", 1, 0, 0, 3, 2, 2);

    step(1, 9);  chk_all("fly9", 1, 1, 0, 4, 2, 5);
    step(0, 9);  chk_all("idle_fly9", 1, 0, 0, 4, 2, 5);
    step(1, 5);  chk_all("fly_ok5", 1, 0, 0, 4, 2, 8);
    step(1, 1);  chk_all("fly1", 1, 1, 0, 5, 2, 11);
    step(1, 11); chk_all("fly_ok11", 1, 0, 0, 5, 2, 14);

    #2 reset = 1'b1;
    #1 chk_all("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 5);  chk_all("hunt5", 0, 0, 0, 0, 0, 0);
    step(1, 0);  chk("r0.exp", bus.expected, 2);
    step(1, 8);  chk_all("track_drop", 0, 0, 0, 0, 0, 0);
    step(1, 0);
    step(1, 2);
    step(1, 5);
    step(1, 8);
    step(1, 11); chk_all("relock11", 0, 0, 0, 0, 0, 14);
    step(1, 14); chk_all("relock14", 1, 0, 0, 0, 0, 0);

    do_reset();
    ec_model = 0;
    for (int i = 0; i < 150; i++) begin
      step(1, 0); step(1, 2); step(1, 5); step(1, 8); step(1, 11); step(1, 14);
      if (i == 0) chk("sat_lock", bus.locked, 1);
      step(1, 3); step(1, 3);
      ec_model = ec_model + 2 > 255 ? 255 : ec_model + 2;
      chk($sformatf("sat_ec[%0d]", i), bus.err_count, ec_model);
    end
    chk_all("sat_end", 0, 1, 0, 255, 0, 0);

    step(1, 0); step(1, 2); step(1, 5); step(1, 8); step(1, 11); step(1, 14);
    chk("wrap_lock", bus.locked, 1);
    for (int j = 0; j < 255; j++) begin
      step(1, 0); step(1, 2); step(1, 5); step(1, 8); step(1, 11); step(1, 14);
    end
    chk_all("wrap255", 1, 0, 0, 255, 255, 0);
    step(1, 0);  chk_all("wrap256", 1, 0, 1, 255, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
